// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issue/writeback sequencer in front of a 4-function ALU
module alu_sequencer #(
    parameter int OPW = 4,
    parameter int DW  = 8,
    parameter int RW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [15:0]    in_instr,
    output logic [OPW-1:0] alu_opcode,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [RW-1:0]  alu_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [RW-1:0]  out_result,
    output logic [1:0]     out_rd,
    output logic           illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;

    state_t         state_q, state_d;
    logic [DW-1:0]  regs_q [4];
    logic [DW-1:0]  regs_d [4];
    logic [OPW-1:0] op_q, op_d;
    logic [DW-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]     rd_q, rd_d, out_rd_q, out_rd_d;
    logic [RW-1:0]  res_q, res_d;
    logic           illegal_q, illegal_d;

    logic [3:0] f_op;
    logic [1:0] f_rd, f_ra, f_rb;
    logic [7:0] f_imm;

    assign f_op  = in_instr[15:12];
    assign f_rd  = in_instr[11:10];
    assign f_ra  = in_instr[9:8];
    assign f_rb  = in_instr[7:6];
    assign f_imm = in_instr[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operands are captured at issue, so a writeback to ra/rb in EXEC is harmless.
    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        out_rd_d  = out_rd_q;
        res_d     = res_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (f_op)
                        OP_ADD, OP_SUB, OP_MUL: begin
                            op_d    = OPW'(f_op);
                            a_d     = regs_q[f_ra];
                            b_d     = regs_q[f_rb];
                            rd_d    = f_rd;
                            state_d = EXEC;
                        end
                        OP_LDI:  regs_d[f_rd] = DW'(f_imm);
                        OP_NOP:  ;
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            EXEC: begin
                res_d        = alu_result;
                out_rd_d     = rd_q;
                regs_d[rd_q] = alu_result[DW-1:0];
                state_d      = RESP;
            end
            RESP: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            out_rd_q  <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            out_rd_q  <= out_rd_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == RESP);
    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign out_result = res_q;
    assign out_rd     = out_rd_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_a, alu_b;
    logic [15:0] alu_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic [1:0]  out_rd;
    logic        illegal;

    int n_chk = 0;
    int n_fail = 0;

    alu_sequencer #(.OPW(4), .DW(8), .RW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Combinational ALU stand-in
    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            4'h1:    alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            4'h2:    alu_result = {8'h00, alu_a} - {8'h00, alu_b};
            4'h3:    alu_result = {8'h00, alu_a} * {8'h00, alu_b};
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {4'h4, rd, 2'b00, imm};
    endfunction

    function automatic logic [15:0] alu_op(input logic [3:0] op, input logic [1:0] rd,
                                           input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, rb, 6'd0};
    endfunction

    task automatic send(input logic [15:0] instr);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        in_valid = 1'b1;
        in_instr = instr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_alu(input string tag, input logic [15:0] instr,
                           input logic [15:0] exp_res, input logic [1:0] exp_rd);
        send(instr);
        check({tag, "_ov_exec"}, out_valid, 0);
        check({tag, "_ir_exec"}, in_ready, 0);
        @(posedge clk);
        #1;
        check({tag, "_ov"}, out_valid, 1);
        check({tag, "_res"}, out_result, exp_res);
        check({tag, "_rd"}, out_rd, exp_rd);
        @(posedge clk);
        #1;
        check({tag, "_idle"}, in_ready, 1);
        check({tag, "_ov_clr"}, out_valid, 0);
    endtask

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_illegal", illegal, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send(ldi(2'd0, 8'h0C));
        send(ldi(2'd1, 8'h05));
        run_alu("add", alu_op(4'h1, 2'd2, 2'd0, 2'd1), 16'h0011, 2'd2);
        check("add_r2", dut.regs_q[2], 8'h11);

        send(ldi(2'd0, 8'h03));
        send(ldi(2'd1, 8'h05));
        run_alu("sub", alu_op(4'h2, 2'd3, 2'd0, 2'd1), 16'hFFFE, 2'd3);
        check("sub_r3", dut.regs_q[3], 8'hFE);
        check("sub_illegal", illegal, 0);

        send(ldi(2'd0, 8'hFF));
        send(ldi(2'd1, 8'hFF));
        run_alu("mul", alu_op(4'h3, 2'd0, 2'd0, 2'd1), 16'hFE01, 2'd0);
        check("mul_r0", dut.regs_q[0], 8'h01);
        run_alu("add2", alu_op(4'h1, 2'd1, 2'd0, 2'd0), 16'h0002, 2'd1);

        // Backpressure: R0=1, R1=2, so R2=3
        out_ready = 1'b0;
        send(alu_op(4'h1, 2'd2, 2'd0, 2'd1));
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_instr = ldi(2'd3, 8'hAA);
        for (int i = 0; i < 5; i++) begin
            check("hold_ov", out_valid, 1);
            check("hold_res", out_result, 16'h0003);
            check("hold_rd", out_rd, 2'd2);
            check("hold_ir", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_ir", in_ready, 1);
        check("hold_release_ov", out_valid, 0);
        check("hold_r3_untouched", dut.regs_q[3], 8'hFE);

        send(16'hA000);
        check("illegal_set", illegal, 1);
        send(16'h0000);
        check("illegal_sticky", illegal, 1);
        check("illegal_no_ov", out_valid, 0);
        check("illegal_r0", dut.regs_q[0], 8'h01);
        check("illegal_r1", dut.regs_q[1], 8'h02);
        check("illegal_r2", dut.regs_q[2], 8'h03);
        check("illegal_r3", dut.regs_q[3], 8'hFE);
        run_alu("post_illegal", alu_op(4'h1, 2'd3, 2'd0, 2'd1), 16'h0003, 2'd3);
        check("post_illegal_flag", illegal, 1);

        // Asynchronous reset while a result is pending
        out_ready = 1'b0;
        send(alu_op(4'h1, 2'd0, 2'd1, 2'd2));
        @(posedge clk);
        #1;
        check("pre_rst_ov", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ov", out_valid, 0);
        check("arst_illegal", illegal, 0);
        check("arst_r0", dut.regs_q[0], 0);
        check("arst_r1", dut.regs_q[1], 0);
        check("arst_r2", dut.regs_q[2], 0);
        check("arst_r3", dut.regs_q[3], 0);
        check("arst_res", out_result, 0);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        run_alu("arst_add", alu_op(4'h1, 2'd0, 2'd0, 2'd1), 16'h0000, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
